// File: rtl/keypad_loader.sv
// Microwave keypad front end: turns digit keys into timer load strobes, keeps a
// shadow of the entered time and sequences cook / pause / done.
module keypad_loader #(
    parameter int DONE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    input  logic       start_key,
    input  logic       stop_key,
    input  logic       timer_zero,
    output logic [3:0] data,
    output logic       loadn,
    output logic       timer_clrn,
    output logic       timer_en,
    output logic [3:0] shadow_ones,
    output logic [3:0] shadow_tens,
    output logic [3:0] shadow_mins,
    output logic       cooking,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE,
        COOK,
        PAUSE,
        DONE
    } state_t;

    localparam int DCW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;
    localparam logic [DCW-1:0] DONE_LAST = DCW'(DONE_CYCLES - 1);

    state_t           state_q,    state_d;
    logic [3:0]       data_q,     data_d;
    logic             loadn_q,    loadn_d;
    logic             clrn_q,     clrn_d;
    logic             en_q,       en_d;
    logic [3:0]       ones_q,     ones_d;
    logic [3:0]       tens_q,     tens_d;
    logic [3:0]       mins_q,     mins_d;
    logic [1:0]       count_q,    count_d;
    logic             cooking_q,  cooking_d;
    logic             done_q,     done_d;
    logic             err_q,      err_d;
    logic [DCW-1:0]   done_cnt_q, done_cnt_d;

    logic digit_ok;
    logic shadow_nonzero;

    assign digit_ok       = key_valid && (key_code <= 4'd9);
    assign shadow_nonzero = (ones_q != 4'd0) || (tens_q != 4'd0) || (mins_q != 4'd0);

    always_comb begin
        // NOTE: every _d defaults to its _q (or its idle level) so no path infers a latch.
        state_d    = state_q;
        data_d     = data_q;
        loadn_d    = 1'b1;
        clrn_d     = 1'b1;
        en_d       = en_q;
        ones_d     = ones_q;
        tens_d     = tens_q;
        mins_d     = mins_q;
        count_d    = count_q;
        cooking_d  = cooking_q;
        done_d     = done_q;
        err_d      = 1'b0;
        done_cnt_d = done_cnt_q;

        // The timer latches the digit on the edge that ends the loadn pulse.
        if (!loadn_q) begin
            mins_d  = tens_q;
            tens_d  = ones_q;
            ones_d  = data_q;
            count_d = count_q + 2'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (stop_key) begin
                    clrn_d  = 1'b0;
                    ones_d  = 4'd0;
                    tens_d  = 4'd0;
                    mins_d  = 4'd0;
                    count_d = 2'd0;
                end else if (start_key) begin
                    if (tens_q > 4'd5) begin
                        err_d = 1'b1;
                    end else if (shadow_nonzero) begin
                        state_d   = COOK;
                        en_d      = 1'b1;
                        cooking_d = 1'b1;
                    end
                end else if (digit_ok && (count_q < 2'd3) && loadn_q) begin
                    data_d  = key_code;
                    loadn_d = 1'b0;
                end
            end
            COOK: begin
                if (timer_zero) begin
                    state_d    = DONE;
                    en_d       = 1'b0;
                    cooking_d  = 1'b0;
                    done_d     = 1'b1;
                    done_cnt_d = '0;
                    ones_d     = 4'd0;
                    tens_d     = 4'd0;
                    mins_d     = 4'd0;
                    count_d    = 2'd0;
                end else if (stop_key) begin
                    state_d   = PAUSE;
                    en_d      = 1'b0;
                    cooking_d = 1'b0;
                end
            end
            PAUSE: begin
                if (stop_key) begin
                    state_d = IDLE;
                    clrn_d  = 1'b0;
                    ones_d  = 4'd0;
                    tens_d  = 4'd0;
                    mins_d  = 4'd0;
                    count_d = 2'd0;
                end else if (start_key) begin
                    state_d   = COOK;
                    en_d      = 1'b1;
                    cooking_d = 1'b1;
                end
            end
            DONE: begin
                if (done_cnt_q == DONE_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end else begin
                    done_cnt_d = done_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (clr) begin
            state_q    <= IDLE;
            data_q     <= 4'd0;
            loadn_q    <= 1'b1;
            clrn_q     <= 1'b1;
            en_q       <= 1'b0;
            ones_q     <= 4'd0;
            tens_q     <= 4'd0;
            mins_q     <= 4'd0;
            count_q    <= 2'd0;
            cooking_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            done_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            loadn_q    <= loadn_d;
            clrn_q     <= clrn_d;
            en_q       <= en_d;
            ones_q     <= ones_d;
            tens_q     <= tens_d;
            mins_q     <= mins_d;
            count_q    <= count_d;
            cooking_q  <= cooking_d;
            done_q     <= done_d;
            err_q      <= err_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    assign data        = data_q;
    assign loadn       = loadn_q;
    assign timer_clrn  = clrn_q;
    assign timer_en    = en_q;
    assign shadow_ones = ones_q;
    assign shadow_tens = tens_q;
    assign shadow_mins = mins_q;
    assign cooking     = cooking_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule
